// File: rtl/range_burst_source.sv
`default_nettype none
// ============================================================================
// Module   : range_burst_source
// Summary  : Buffers up to DEPTH samples and replays them as one go/finish
//            framed burst into a range-finder sink, then captures its range.
//            Build option RBS_REPLAY_EN keeps the loaded samples for replay.
// Revision : 1.0 - initial release
// ============================================================================
module range_burst_source #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     go,
    output logic                     finish,
    input  logic [WIDTH-1:0]         range_in,
    output logic [WIDTH-1:0]         result,
    output logic                     result_valid
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_AW-1:0] c_IDX_ONE   = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_TWO   = c_CW'(2);
    localparam logic [c_CW-1:0] c_CNT_DEPTH = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_buf [DEPTH];
    logic [c_CW-1:0]    r_count;
    logic [c_AW-1:0]    r_idx;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_go;
    logic               r_finish;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_valid;

    logic [c_CW-1:0]    w_count_nxt;
    logic [c_AW-1:0]    w_idx_nxt;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               w_go_nxt;
    logic               w_finish_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_result_valid_nxt;
    logic               w_buf_we;
    logic               w_full;
    logic               w_last;
    logic               w_penult;

    assign w_full   = (r_count == c_CNT_DEPTH);
    // r_idx is the beat currently on the outputs; last/penultimate decide framing
    assign w_last   = (({1'b0, r_idx} + c_CNT_ONE) == r_count);
    assign w_penult = (({1'b0, r_idx} + c_CNT_TWO) == r_count);

    always_comb begin
        w_state_nxt        = r_state;
        w_count_nxt        = r_count;
        w_idx_nxt          = r_idx;
        w_data_nxt         = '0;
        w_go_nxt           = 1'b0;
        w_finish_nxt       = 1'b0;
        w_busy_nxt         = 1'b0;
        w_done_nxt         = 1'b0;
        w_err_nxt          = r_err;
        w_result_nxt       = r_result;
        w_result_valid_nxt = r_result_valid;
        w_buf_we           = 1'b0;

        case (r_state)
            S_IDLE: begin
                // start has priority; a coincident write is silently dropped
                if (start) begin
                    if (r_count >= c_CNT_TWO) begin
                        w_state_nxt        = S_SEND;
                        w_idx_nxt          = '0;
                        w_data_nxt         = r_buf[0];
                        w_go_nxt           = 1'b1;
                        w_busy_nxt         = 1'b1;
                        w_err_nxt          = 1'b0;
                        w_result_valid_nxt = 1'b0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (wr_en) begin
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_buf_we    = 1'b1;
                        w_count_nxt = r_count + c_CNT_ONE;
                    end
                end
            end

            S_SEND: begin
                w_busy_nxt = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_idx_nxt    = r_idx + c_IDX_ONE;
                    w_data_nxt   = r_buf[w_idx_nxt];
                    w_finish_nxt = w_penult;
                end
            end

            S_CAPTURE: begin
                w_state_nxt        = S_IDLE;
                w_result_nxt       = range_in;
                w_result_valid_nxt = 1'b1;
                w_done_nxt         = 1'b1;
`ifndef RBS_REPLAY_EN
                w_count_nxt        = '0;
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count        <= '0;
            r_idx          <= '0;
            r_data_out     <= '0;
            r_go           <= 1'b0;
            r_finish       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_count        <= w_count_nxt;
            r_idx          <= w_idx_nxt;
            r_data_out     <= w_data_nxt;
            r_go           <= w_go_nxt;
            r_finish       <= w_finish_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_err          <= w_err_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
        end
    end

    // Sample storage has no reset; contents are only read below r_count
    always_ff @(posedge clock) begin
        if (w_buf_we) begin
            r_buf[r_count[c_AW-1:0]] <= wr_data;
        end
    end

    assign count        = r_count;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign data_out     = r_data_out;
    assign go           = r_go;
    assign finish       = r_finish;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_range_burst_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_burst_source
// Summary  : Scoreboard bench for range_burst_source with a behavioural sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_burst_source;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             g;
        logic             f;
    } beat_t;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic             wr_en   = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start   = 1'b0;
    logic [CW-1:0]    count;
    logic             busy, done, err, go, finish, result_valid;
    logic [WIDTH-1:0] data_out, result, range_in;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t            exp_beats[$];
    logic [WIDTH-1:0] exp_results[$];

    // reference model state
    logic [WIDTH-1:0] model_buf[$];
    logic             model_err;
    logic             model_seen;
    logic [WIDTH-1:0] model_min, model_max;

    always #5 clock = ~clock;

    range_burst_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .start        (start),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .data_out     (data_out),
        .go           (go),
        .finish       (finish),
        .range_in     (range_in),
        .result       (result),
        .result_valid (result_valid)
    );

    // Behavioural range-finder sink: cumulative min/max since its reset
    logic             sink_seen, sink_active;
    logic [WIDTH-1:0] sink_min, sink_max;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sink_seen   <= 1'b0;
            sink_active <= 1'b0;
            sink_min    <= '0;
            sink_max    <= '0;
        end else begin
            if (go || sink_active) begin
                sink_seen <= 1'b1;
                sink_min  <= (!sink_seen || data_out < sink_min) ? data_out : sink_min;
                sink_max  <= (!sink_seen || data_out > sink_max) ? data_out : sink_max;
            end
            if (go)     sink_active <= 1'b1;
            if (finish) sink_active <= 1'b0;
        end
    end
    assign range_in = sink_seen ? (sink_max - sink_min) : '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: pops expected beats/results whenever the DUT presents them
    bit    in_burst = 1'b0;
    beat_t mb;
    always @(negedge clock) begin
        if (!reset_n) begin
            in_burst = 1'b0;
        end else begin
            if (go && finish) check("go_finish_overlap", 1, 0);
            if (go || in_burst) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mb = exp_beats.pop_front();
                    check("beat_data", data_out, mb.d);
                    check("beat_go", go, mb.g);
                    check("beat_finish", finish, mb.f);
                end
                in_burst = !finish;
            end
            if (done) begin
                if (exp_results.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("result", result, exp_results.pop_front());
                    check("result_valid", result_valid, 1);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        model_buf.delete();
        model_err  = 1'b0;
        model_seen = 1'b0;
        model_min  = '0;
        model_max  = '0;
        exp_beats.delete();
        exp_results.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        cyc();
        cyc();
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc();
    endtask

    task automatic do_write(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
        if (model_buf.size() < DEPTH) model_buf.push_back(d);
        else                          model_err = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, count, model_buf.size());
        check({tag, "_err"}, err, model_err);
    endtask

    task automatic do_start(input bit with_write, input bit poke);
        int n;
        int lat;
        n     = model_buf.size();
        start = 1'b1;
        if (with_write) begin
            wr_en   = 1'b1;
            wr_data = WIDTH'($urandom);
        end
        cyc();
        start = 1'b0;
        wr_en = 1'b0;
        if (n >= 2) begin
            for (int i = 0; i < n; i++) begin
                beat_t b;
                b.d = model_buf[i];
                b.g = (i == 0);
                b.f = (i == n - 1);
                exp_beats.push_back(b);
                if (!model_seen || model_buf[i] < model_min) model_min = model_buf[i];
                if (!model_seen || model_buf[i] > model_max) model_max = model_buf[i];
                model_seen = 1'b1;
            end
            exp_results.push_back(model_max - model_min);
            model_err = 1'b0;
            check("busy_on_start", busy, 1);
            check("err_on_accept", err, 0);
            check("rv_cleared", result_valid, 0);
            lat = 1;
            while (!done && lat < n + 10) begin
                check("busy_in_burst", busy, 1);
                if (poke) begin
                    start   = 1'b1;
                    wr_en   = 1'b1;
                    wr_data = WIDTH'($urandom);
                end
                cyc();
                start = 1'b0;
                wr_en = 1'b0;
                lat++;
            end
            check("done_latency", lat, n + 2);
            check("busy_at_done", busy, 0);
            check("rv_at_done", result_valid, 1);
`ifndef RBS_REPLAY_EN
            model_buf.delete();
`endif
            check_status("after_burst");
            cyc();
            check("done_one_cycle", done, 0);
        end else begin
            model_err = 1'b1;
            check("reject_busy", busy, 0);
            check("reject_err", err, 1);
            cyc();
            cyc();
            check("reject_busy_later", busy, 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nload;
        model_clear();
        #1 reset_n = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_go", go, 0);
        check("rst_finish", finish, 0);
        check("rst_rv", result_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_result", result, 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc();

        // Basic burst; sink fresh so result is 9 - 2
        do_write(16'd5); do_write(16'd9); do_write(16'd2); do_write(16'd7);
        check_status("load4");
        do_start(0, 0);
        check("first_result", result, 7);
        // Replay (or rejection without replay support)
        do_start(0, 0);
        check_status("second_start");

        // Single sample rejected, then a two-sample burst
        do_reset();
        do_write(16'd3);
        do_start(0, 0);
        check_status("single");
        do_write(16'd8);
        do_start(0, 0);
        check("pair_result", result, 5);

        // Overflow, then a burst with mid-burst pokes
        do_reset();
        for (int i = 0; i <= DEPTH; i++) do_write(WIDTH'(100 + i * 3));
        check_status("overflow");
        do_start(0, 1);

        // start and wr_en in the same idle cycle
        do_reset();
        do_write(16'd40); do_write(16'd10);
        do_start(1, 0);
        check_status("same_cycle");

        // Reset during beat k=1
        do_reset();
        for (int i = 0; i < 4; i++) do_write(WIDTH'(20 + i));
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.d = model_buf[i];
            b.g = (i == 0);
            b.f = (i == 3);
            exp_beats.push_back(b);
        end
        cyc();
        #1 reset_n = 1'b0;
        model_clear();
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_go", go, 0);
        check("mid_rst_finish", finish, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rv", result_valid, 0);
        check("mid_rst_result", result, 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc();
        do_write(16'd11); do_write(16'd4); do_write(16'd6);
        do_start(0, 0);

        // Randomized bursts
        for (int it = 0; it < 12; it++) begin
            nload = $urandom_range(0, DEPTH - model_buf.size());
            if (model_buf.size() + nload < 2) nload = 2 - model_buf.size();
            for (int i = 0; i < nload; i++) do_write(WIDTH'($urandom));
            check_status("rand_load");
            do_start(0, bit'($urandom_range(0, 1)));
        end

        cyc();
        cyc();
        check("beats_drained", exp_beats.size(), 0);
        check("results_drained", exp_results.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/range_burst_source.md
# range_burst_source

Transmit-side partner for the range-finder sink. Software or a test harness loads up to DEPTH samples into an internal buffer. On `start`, the block replays the buffer as one framed burst on the sink's `data_in`/`go`/`finish` interface, then captures the sink's `range` output into a result register. It sits directly upstream of the range finder and owns all burst framing, so the sink never sees an illegal `go`+`finish` pair.

## Interface
- `WIDTH`, default 16: sample and result width; matches sink `WIDTH`.
- `DEPTH`, default 8: buffer entries; power of 2, minimum 2.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: load `wr_data` into the next buffer slot.
- `wr_data`  in  WIDTH: sample to load.
- `start`  in  1: request playback of the loaded samples.
- `count`  out  $clog2(DEPTH)+1: number of samples loaded.
- `busy`  out  1: high from the accepted start through the capture cycle.
- `done`  out  1: one-cycle pulse when `result` updates.
- `err`  out  1: sticky error flag.
- `data_out`  out  WIDTH: to sink `data_in`.
- `go`  out  1: to sink `go`.
- `finish`  out  1: to sink `finish`.
- `range_in`  in  WIDTH: from sink `range`.
- `result`  out  WIDTH: captured range.
- `result_valid`  out  1: `result` holds a captured value.

## Operation
- FSM states:
  - IDLE → SEND: on an accepted start.
  - SEND → CAPTURE: after the last sample.
  - CAPTURE → IDLE: always, after one cycle.
- Load path: `wr_en` in IDLE with `count < DEPTH` writes `buf[count]` and increments `count`. A write when `count == DEPTH` is dropped and sets `err`. `wr_en` outside IDLE is ignored with no error.
- Start rules:
  - `start` in IDLE with `count >= 2` is accepted: clears `err`, clears `result_valid`, resets the read index to 0.
  - `start` in IDLE with `count < 2` is rejected: sets `err`, state stays IDLE. A single-sample burst would need `go`+`finish` together, which the sink flags as an error.
  - `start` outside IDLE is ignored.
- `wr_en` and `start` in the same IDLE cycle: start is evaluated first; the write is dropped with no error.
- SEND, read index k = 0..N-1 with N = `count`:
  - `data_out = buf[k]` every cycle.
  - `go = 1` only at k=0.
  - `finish = 1` only at k=N-1.
  - `go` and `finish` are never high together.
- CAPTURE: `go`, `finish` and `data_out` are 0. `range_in` is registered into `result` at the end of this cycle.
- The sink clears min/max only on its own reset. `result` is the sink's cumulative range, reported as-is.
- Arithmetic: `count` and the index are unsigned and saturate by construction, with no wrap. `result` is not modified.
- All outputs are registered. In IDLE: `data_out = 0`, `go = 0`, `finish = 0`.

## Timing
- Start sampled at edge E: `busy = 1` and `go = 1` with `buf[0]` from E+1. `finish` with `buf[N-1]` during cycle E+N. CAPTURE during E+N+1.
- At E+N+2: `result` valid, `result_valid = 1`, `done = 1` for that one cycle, `busy = 0`, state IDLE.
- Burst occupancy is N+1 busy cycles. A new start is accepted at the earliest in cycle E+N+2.
- Reset values, applied immediately on `reset_n` low, including mid-burst:
  - state IDLE, `count = 0`.
  - `busy`, `done`, `err`, `go`, `finish`, `result_valid` = 0.
  - `data_out = 0`, `result = 0`.
  - Buffer contents undefined.

## Configuration
- `RBS_REPLAY_EN` defined: `count` and the buffer are retained after CAPTURE, so a later start replays the same burst.
- `RBS_REPLAY_EN` undefined: `count` clears to 0 on the CAPTURE→IDLE transition, and new samples must be loaded before the next start.

## Test plan
- Load 5, 9, 2, 7 and start, with the sink fresh from reset → `go` with 5, then 9, 2, `finish` with 7. `result = 7`, `done` pulses 6 cycles after the start edge.
- Load a single sample 3 and start → `err = 1`, `go`/`finish` never assert, `busy` stays 0. Then load 8 and start → `err` clears and the burst 3, 8 plays.
- Write DEPTH+1 samples → `count = DEPTH`, `err = 1`, the extra sample is absent from playback.
- `start` and `wr_en` pulsed mid-burst → no effect on framing or `count`. `start` and `wr_en` in the same IDLE cycle → burst starts and the write is dropped.
- Assert `reset_n` low during SEND at k=1 → all outputs go to their reset values immediately, `count = 0`, and a subsequent load/start works normally.
- With `RBS_REPLAY_EN`: second start after the first burst replays the same data, `count` unchanged. Without it: `count = 0` after `done`, and a second start sets `err`.
